writeback_arb: RTL and testbench

Writeback stage that sits directly downstream of the execute units (ALU, multiplier, etc.) and consumes their X→W interfaces. Each cycle it picks at most one valid execute result by round-robin arbitration and registers it. The next cycle it drives a single register-file write port and a retired-instruction counter. The registered write port doubles as the bypass source for decode.

---
 rtl/writeback_arb_pkg.sv | 8 +
 rtl/writeback_arb_rr_arbiter.sv | 31 +++
 rtl/writeback_arb.sv | 66 ++++++
 tb/tb_writeback_arb.sv | 133 +++++++++++++
 4 files changed

// File: rtl/writeback_arb_pkg.sv
// writeback_arb_pkg: register-address width and the x0 write-suppression helper shared by writeback
package writeback_arb_pkg;
   localparam int reg_addr_bits = 5;
   typedef logic [reg_addr_bits-1:0] reg_addr_t;
   function automatic logic writes_reg(input logic wen, input reg_addr_t waddr);
      return wen && waddr != '0;
   endfunction
endpackage

// File: rtl/writeback_arb_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; priority starts at ptr and wraps, ptr moves past each winner
module rr_arbiter #(
   parameter int p_width = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               xfer_en,
   input  logic [p_width-1:0] req,
   output logic [p_width-1:0] gnt
);
   localparam int pw = p_width > 1 ? $clog2(p_width) : 1;
   logic [pw-1:0] ptr, ptr_nxt;
   int j;
   // Walk from farthest to nearest so the pipe closest to ptr overwrites any earlier pick
   always_comb begin
      gnt = '0;
      ptr_nxt = ptr;
      j = 0;
      for (int k = p_width - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % p_width;
         if (xfer_en && req[j]) begin
            gnt = '0;
            gnt[j] = 1'b1;
            ptr_nxt = pw'((j + 1) % p_width);
         end
      end
   end
   always_ff @(posedge clk)
      if (!rst) ptr <= '0;
      else if (|gnt) ptr <= ptr_nxt;
endmodule

// File: rtl/writeback_arb.sv
// writeback_arb: arbitrates execute results onto one registered register-file write port and counts retirements
module writeback_arb
   import writeback_arb_pkg::*;
#(
   parameter int p_num_pipes = 2,
   parameter int p_data_bits = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [p_num_pipes-1:0]               x_val,
   output logic [p_num_pipes-1:0]               x_rdy,
   input  logic [p_num_pipes-1:0]               x_wen,
   input  logic [reg_addr_bits*p_num_pipes-1:0] x_waddr,
   input  logic [p_data_bits*p_num_pipes-1:0]   x_wdata,
   output logic                                 rf_wen,
   output logic [reg_addr_bits-1:0]             rf_waddr,
   output logic [p_data_bits-1:0]               rf_wdata,
   output logic [31:0]                          retired
);
   typedef struct packed {
      logic                   wen;
      reg_addr_t              waddr;
      logic [p_data_bits-1:0] wdata;
   } wb_result_t;
   wb_result_t pipe_res [p_num_pipes];
   wb_result_t sel, res;
   int sel_pipe, pipe_q;
   for (genvar i = 0; i < p_num_pipes; i++) begin : g_pipe
      assign pipe_res[i] = {x_wen[i], x_waddr[reg_addr_bits*i +: reg_addr_bits], x_wdata[p_data_bits*i +: p_data_bits]};
   end
   // Grant is gated by rst so nothing transfers while reset is held
   rr_arbiter #(.p_width(p_num_pipes)) u_arb (
      .clk(clk),
      .rst(rst),
      .xfer_en(rst),
      .req(x_val),
      .gnt(x_rdy)
   );
   always_comb begin
      sel = '0;
      sel_pipe = 0;
      for (int i = 0; i < p_num_pipes; i++)
         if (x_rdy[i]) begin
            sel = pipe_res[i];
            sel_pipe = i;
         end
   end
   always_ff @(posedge clk)
      if (!rst) begin
         res <= '0;
         retired <= '0;
         pipe_q <= 0;
      end else if (|x_rdy) begin
         res <= '{wen: writes_reg(sel.wen, sel.waddr), waddr: sel.waddr, wdata: sel.wdata};
         retired <= retired + 32'd1;
         pipe_q <= sel_pipe;
      end else res.wen <= 1'b0;
   assign rf_wen = res.wen;
   assign rf_waddr = res.waddr;
   assign rf_wdata = res.wdata;
`ifndef SYNTHESIS
   function automatic string linetrace();
      return rf_wen ? $sformatf("p%0d x%0d=%h", pipe_q, rf_waddr, rf_wdata) : "";
   endfunction
`endif
endmodule

// File: tb/tb_writeback_arb.sv
// tb_writeback_arb: directed vectors on a 3-pipe writeback_arb, checked by a queue-fed monitor
module tb_writeback_arb;
   logic clk = 0, rst = 0;
   logic [2:0] x_val = '0, x_wen = '0, x_rdy;
   logic [14:0] x_waddr = '0;
   logic [95:0] x_wdata = '0;
   logic rf_wen;
   logic [4:0] rf_waddr;
   logic [31:0] rf_wdata, retired;
   typedef struct packed {
      logic [2:0]  gnt;
      logic        wen;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];
   int vectors = 0, miscompares = 0;
   logic armed = 0, exp_wen = 0;
   logic [4:0] exp_addr = '0;
   logic [31:0] exp_data = '0, exp_ret = '0;
   localparam logic [14:0] addr_d = {5'd12, 5'd11, 5'd10};
   localparam logic [95:0] data_d = {32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};

   always #5 clk = ~clk;

   writeback_arb #(.p_num_pipes(3), .p_data_bits(32)) dut (
      .clk(clk),
      .rst(rst),
      .x_val(x_val),
      .x_rdy(x_rdy),
      .x_wen(x_wen),
      .x_waddr(x_waddr),
      .x_wdata(x_wdata),
      .rf_wen(rf_wen),
      .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata),
      .retired(retired)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: rf outputs reflect the previous cycle's grant; hold values carry over on idle cycles
   always @(negedge clk) begin
      exp_t e;
      if (armed) begin
         chk("rf_wen", 32'(rf_wen), 32'(exp_wen));
         chk("rf_waddr", 32'(rf_waddr), 32'(exp_addr));
         chk("rf_wdata", rf_wdata, exp_data);
         chk("retired", retired, exp_ret);
      end
      if (!rst) begin
         chk("rdy_in_reset", 32'(x_rdy), 32'd0);
         exp_wen = 0;
         exp_addr = '0;
         exp_data = '0;
         exp_ret = '0;
         armed = 1;
      end else if (x_rdy != 0) begin
         if (sb.size() == 0) chk("unexpected_grant", 32'(x_rdy), 32'd0);
         else begin
            e = sb.pop_front();
            chk("grant", 32'(x_rdy), 32'(e.gnt));
            exp_wen = e.wen;
            exp_addr = e.addr;
            exp_data = e.data;
            exp_ret = exp_ret + 32'd1;
         end
      end else begin
         exp_wen = 0;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("missing_grant", 32'(x_rdy), 32'(e.gnt));
         end
      end
   end

   task automatic cyc(input logic r, input logic [2:0] val, input logic [2:0] wen, input logic [14:0] addr,
                      input logic [95:0] data, input int gp, input logic ew);
      @(posedge clk);
      #1;
      rst = r;
      x_val = val;
      x_wen = wen;
      x_waddr = addr;
      x_wdata = data;
      if (gp >= 0) sb.push_back({3'(1 << gp), ew, addr[5*gp +: 5], data[32*gp +: 32]});
   endtask

   task automatic go(input logic [2:0] val, input int gp);
      cyc(1'b1, val, 3'b111, addr_d, data_d, gp, 1'b1);
   endtask

   initial begin
      cyc(1'b0, 3'b111, 3'b111, addr_d, data_d, -1, 1'b0);
      cyc(1'b0, 3'b111, 3'b111, addr_d, data_d, -1, 1'b0);
      go(3'b111, 0);
      go(3'b000, -1);
      cyc(1'b1, 3'b010, 3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEAD_BEEF, 32'h0}, 1, 1'b1);
      go(3'b000, -1);
      go(3'b011, 0); go(3'b011, 1); go(3'b011, 0); go(3'b011, 1); go(3'b011, 0); go(3'b011, 1);
      go(3'b111, 2); go(3'b111, 0); go(3'b111, 1); go(3'b111, 2); go(3'b111, 0); go(3'b111, 1);
      go(3'b001, 0);
      go(3'b001, 0);
      go(3'b111, 1);
      go(3'b011, 0);
      cyc(1'b1, 3'b010, 3'b111, {5'd12, 5'd0, 5'd10}, data_d, 1, 1'b0);
      cyc(1'b1, 3'b100, 3'b011, {5'd7, 5'd11, 5'd10}, {32'h7777_0007, 32'hB0B0_0001, 32'hA0A0_0000}, 2, 1'b0);
      go(3'b000, -1);
      #2;
      force dut.retired = 32'hFFFF_FFFF;
      exp_ret = 32'hFFFF_FFFF;
      #1;
      release dut.retired;
      go(3'b111, 0);
      go(3'b000, -1);
      cyc(1'b0, 3'b011, 3'b111, addr_d, data_d, -1, 1'b0);
      go(3'b011, 0);
      go(3'b010, 1);
      go(3'b000, -1);
      go(3'b000, -1);
      @(posedge clk);
      #1;
      chk("leftover_expectations", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
